// File: rtl/fp_to_int.sv
// Multi-cycle IEEE-754 single to int32 converter, truncating toward zero.
// Define FP2I_SATURATE_EN to saturate overflow by sign instead of always returning 0x80000000.
module fp_to_int (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_fp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_int,
    output logic        out_ovf,
    output logic        out_inexact
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] SIGN  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_mag;
    logic [4:0]  r_cnt;
    logic        r_left;
    logic        r_sticky;
    logic        r_ovf;
    logic        r_sign;
    logic [31:0] r_out_int;
    logic        r_out_ovf;
    logic        r_out_inexact;

    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic [23:0] w_mant;
    logic [31:0] w_mag_init;
    logic [4:0]  w_cnt_init;
    logic        w_left_init;
    logic        w_sticky_init;
    logic        w_ovf_init;
    logic        w_sign_init;

    assign w_exp  = in_fp[30:23];
    assign w_frac = in_fp[22:0];
    assign w_mant = (w_exp != 8'd0) ? {1'b1, w_frac} : 24'd0;

    // Classify the operand at accept time; SHIFT then only runs the chosen shift.
    always_comb begin
        w_mag_init    = 32'd0;
        w_cnt_init    = 5'd0;
        w_left_init   = 1'b0;
        w_sticky_init = 1'b0;
        w_ovf_init    = 1'b0;
        w_sign_init   = in_fp[31];
        if (w_exp == 8'd0) begin
            w_sticky_init = 1'b0;
        end else if (w_exp < 8'd127) begin
            w_sticky_init = 1'b1;
        end else if (w_exp <= 8'd149) begin
            w_mag_init = {8'd0, w_mant};
            w_cnt_init = 5'(8'd150 - w_exp);
        end else if (w_exp <= 8'd157) begin
            w_mag_init  = {8'd0, w_mant};
            w_cnt_init  = 5'(w_exp - 8'd150);
            w_left_init = 1'b1;
        end else if (in_fp[31] && (w_exp == 8'd158) && (w_frac == 23'd0)) begin
            w_mag_init = 32'h8000_0000;
        end else begin
            w_ovf_init  = 1'b1;
            // NaN saturates positive regardless of its sign bit
            w_sign_init = in_fp[31] & ~((w_exp == 8'hFF) && (w_frac != 23'd0));
        end
    end

    logic [2:0]  w_step;
    logic [31:0] w_mask;
    logic [31:0] w_shr;
    logic        w_lost;
    logic [4:0]  w_cnt_next;
    logic [31:0] w_result;
    logic [31:0] w_ovf_val;

    assign w_step     = (r_cnt > 5'd4) ? 3'd4 : r_cnt[2:0];
    assign w_mask     = (32'd1 << w_step) - 32'd1;
    assign w_shr      = r_mag >> w_step;
    assign w_lost     = |(r_mag & w_mask);
    assign w_cnt_next = r_cnt - {2'b00, w_step};
    assign w_result   = r_sign ? (32'd0 - r_mag) : r_mag;

`ifdef FP2I_SATURATE_EN
    assign w_ovf_val = r_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    assign w_ovf_val = 32'h8000_0000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_mag         <= 32'd0;
            r_cnt         <= 5'd0;
            r_left        <= 1'b0;
            r_sticky      <= 1'b0;
            r_ovf         <= 1'b0;
            r_sign        <= 1'b0;
            r_out_int     <= 32'd0;
            r_out_ovf     <= 1'b0;
            r_out_inexact <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mag    <= w_mag_init;
                        r_cnt    <= w_cnt_init;
                        r_left   <= w_left_init;
                        r_sticky <= w_sticky_init;
                        r_ovf    <= w_ovf_init;
                        r_sign   <= w_sign_init;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_left) begin
                        r_mag   <= r_mag << r_cnt;
                        r_state <= SIGN;
                    end else begin
                        // At most four bits per cycle; dropped bits feed the sticky flag
                        r_mag    <= w_shr;
                        r_sticky <= r_sticky | w_lost;
                        r_cnt    <= w_cnt_next;
                        if (w_cnt_next == 5'd0) begin
                            r_state <= SIGN;
                        end
                    end
                end
                SIGN: begin
                    r_out_int     <= r_ovf ? w_ovf_val : w_result;
                    r_out_ovf     <= r_ovf;
                    r_out_inexact <= r_sticky;
                    r_state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign out_int     = r_out_int;
    assign out_ovf     = r_out_ovf;
    assign out_inexact = r_out_inexact;

endmodule

// File: doc/fp_to_int.md
FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  input  1  in_fp holds an operand.
REQ-004 SHALL have: in_ready  output  1  block accepts an operand this cycle.
REQ-005 SHALL have: in_fp  input  32  IEEE-754 single (sign[31], exp[30:23], frac[22:0]).
REQ-006 SHALL have: out_valid  output  1  result fields valid.
REQ-007 SHALL have: out_ready  input  1  consumer accepts the result.
REQ-008 SHALL have: out_int  output  32  two's-complement signed result.
REQ-009 SHALL have: out_ovf  output  1  operand is outside the int32 range, or is Inf/NaN.
REQ-010 SHALL have: out_inexact  output  1  nonzero fraction bits were discarded.

Function
REQ-011 SHALL be an FSM with states IDLE, SHIFT, SIGN and DONE; in_ready=1 only in IDLE.
REQ-012 SHALL accept an operand when in_valid&in_ready, then enter SHIFT next cycle; in_fp is ignored outside IDLE.
REQ-013 SHALL unpack with mant={1,frac} if exp!=0, else mant=0; denormals flush to 0 with inexact=0.
REQ-014 SHALL round toward zero (truncate) on the magnitude, then negate if sign=1.
REQ-015 For exp<127, result SHALL be 0 with inexact=(mant!=0).
REQ-016 For 127<=exp<=149, SHALL right-shift mant by r=150-exp (1..23).
REQ-017 SHIFT SHALL shift at most 4 bits per cycle and OR shifted-out bits into a sticky inexact flag.
REQ-018 SHIFT SHALL take max(1,ceil(r/4)) cycles.
REQ-019 For 150<=exp<=157, SHALL left-shift by exp-150 in one SHIFT cycle with inexact=0.
REQ-020 For exp>=158 (including 255 Inf/NaN), SHALL set out_ovf=1, except sign=1, exp=158, frac=0, which SHALL give 0x80000000 with out_ovf=0.
REQ-021 SIGN SHALL take one cycle to negate, select the overflow value and register outputs, then enter DONE.
REQ-022 out_valid SHALL assert in cycle 2+max(1,ceil(r/4)) after the accept cycle (cycle 0).
REQ-023 SHALL hold out_valid and outputs stable in DONE until out_ready=1, then enter IDLE.
REQ-024 out_ready SHALL be ignored when out_valid=0.
REQ-025 Back-to-back throughput SHALL be one operand per (latency+1) cycles minimum; no pipelining.

Reset
REQ-026 rst=1 SHALL force IDLE on the next edge, with in_ready=1, out_valid=0, out_int=0, out_ovf=0, out_inexact=0.
REQ-027 rst during SHIFT, SIGN or DONE SHALL drop the transaction without producing an output.
REQ-028 rst SHALL override in_valid in the same cycle; no operand is accepted.

Configuration
REQ-029 SHALL use macro FP2I_SATURATE_EN.
REQ-030 With FP2I_SATURATE_EN defined, overflow SHALL give +ovf/+Inf/NaN -> 0x7FFFFFFF and -ovf/-Inf -> 0x80000000.
REQ-031 Without FP2I_SATURATE_EN, every overflow SHALL give 0x80000000.
REQ-032 out_ovf SHALL be identical in both builds.

Verification
REQ-033 Bench SHALL cover: 0x3F800000 (1.0) -> out_int=1, inexact=0, ovf=0, out_valid in cycle 8.
REQ-034 Bench SHALL cover: 0x42C90000 (100.5) -> out_int=100, inexact=1, out_valid in cycle 7; 0xC0200000 (-2.5) -> 0xFFFFFFFE, inexact=1.
REQ-035 Bench SHALL cover: 0x4E800000 (2^30) -> 0x40000000, out_valid in cycle 3; 0xCF000000 -> 0x80000000, ovf=0.
REQ-036 Bench SHALL cover: 0x4F32D05E (3e9) -> ovf=1, giving 0x7FFFFFFF with FP2I_SATURATE_EN and 0x80000000 without; 0x7FC00000 (NaN) -> ovf=1.
REQ-037 Bench SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; release -> IDLE next cycle.
REQ-038 Bench SHALL cover: rst asserted in SHIFT of 0x3F800000 -> no out_valid, all outputs 0, and the next operand converts correctly.
